alu_op_sequencer: RTL and testbench

Sequential front-end that sits directly upstream of the combinational `ALU` (parameter `N_PARAMETER`; opcode 0 = add, 1 = or, 2 = sub, 3 = xor). It accepts one command at a time over a valid/ready handshake and holds the operands and opcode stable on registered outputs that drive the ALU. It captures the ALU result and presents it on a valid/ready result port. An internal accumulator allows a command to use the previous result as operand A, so multi-step expressions can be chained.

---
 rtl/alu_op_sequencer.sv | 111 +++++++++++
 tb/tb_alu_op_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Sequential front-end for a combinational ALU (opcode 0 = add, 1 = or,
// 2 = sub, 3 = xor). One command at a time is accepted over a valid/ready
// handshake. Its operands and opcode are held on registered outputs that
// drive the ALU, and the ALU result is captured one cycle later and presented
// on a valid/ready result port. An internal accumulator holds the last result,
// so a command can chain by using that result as operand A.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  block can accept a command (IDLE only)
//   cmd_opcode   in   ALU opcode for the command
//   cmd_a        in   operand A (ignored when cmd_chain = 1)
//   cmd_b        in   operand B
//   cmd_chain    in   1 = use the accumulator as operand A
//   alu_opcode   out  registered opcode to the ALU
//   alu_a        out  registered operand A to the ALU
//   alu_b        out  registered operand B to the ALU
//   alu_result   in   combinational ALU result
//   res_valid    out  result available (DONE only)
//   res_ready    in   consumer takes the result
//   res_data     out  captured result
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int N_PARAMETER = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_opcode,
  input  logic [N_PARAMETER-1:0] cmd_a,
  input  logic [N_PARAMETER-1:0] cmd_b,
  input  logic                   cmd_chain,
  output logic [1:0]             alu_opcode,
  output logic [N_PARAMETER-1:0] alu_a,
  output logic [N_PARAMETER-1:0] alu_b,
  input  logic [N_PARAMETER-1:0] alu_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N_PARAMETER-1:0] res_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [N_PARAMETER-1:0]   acc;
  logic                     accept;
  logic                     capture;

  // Handshake outputs depend on the state register only, so neither
  // cmd_valid nor res_ready has a combinational path to them.
  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign capture = (state_q == EXEC);

  // NOTE: state_d gets its default before the case so every path assigns it;
  // without that, a missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every datapath register is reset, not just the control state: a
  // reset must visibly clear the ALU operands, the result and the accumulator,
  // and an in-flight command must leave no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_data   <= '0;
      acc        <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= cmd_opcode;
        alu_b      <= cmd_b;
        alu_a      <= cmd_chain ? acc : cmd_a;
      end
      // EXEC is the ALU settle cycle; the result is sampled at its end.
      if (capture) begin
        res_data <= alu_result;
        acc      <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer (N_PARAMETER = 4) with a behavioural
// ALU on its operand outputs. Inputs are driven 1 ns after the rising edge
// and outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_opcode;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         cmd_chain;
  logic [1:0]   alu_opcode;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;

  int vectors;
  int miscompares;

  alu_op_sequencer #(.N_PARAMETER(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_chain  (cmd_chain),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  function automatic logic [N-1:0] alu_ref(input logic [1:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a | b;
      2'd2:    r = a - b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Downstream combinational ALU.
  always_comb alu_result = alu_ref(alu_opcode, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Presents a command and returns 1 ns after its accept edge (state EXEC).
  task automatic issue(input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic chain);
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_chain  = chain;
    cmd_valid  = 1'b1;
    wait_ready();
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Waits (bounded) for the result, checks it and hands it off.
  task automatic take_result(input string tag, input logic [N-1:0] exp);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check(tag, 32'(res_data), 32'(exp));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  logic [1:0]   r_op;
  logic [N-1:0] r_a, r_b, exp_a, exp_r, acc_m;
  logic         r_chain;
  int           stall;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_opcode  = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_chain   = 1'b0;
    res_ready   = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    rst = 1'b0;

    // Chain immediately after reset: acc = 0, so 0 + 6 = 6.
    issue(2'd0, 4'hF, 4'h6, 1'b1);
    check("chain0_alu_a", 32'(alu_a), 32'd0);
    take_result("chain0_res", 4'h6);

    // Add latency: 7 + 5 = 0xC, valid one edge after accept.
    issue(2'd0, 4'h7, 4'h5, 1'b0);
    check("add_exec_valid", 32'(res_valid), 32'd0);
    check("add_exec_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("add_done_valid", 32'(res_valid), 32'd1);
    check("add_done_data",  32'(res_data),  32'hC);
    check("add_done_ready", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("add_taken_ready", 32'(cmd_ready), 32'd1);
    check("add_taken_valid", 32'(res_valid), 32'd0);

    // Wrap-around: 3 - 5 = 0xE, 9 + 9 = 0x2.
    issue(2'd2, 4'h3, 4'h5, 1'b0);
    take_result("sub_wrap", 4'hE);
    issue(2'd0, 4'h9, 4'h9, 1'b0);
    take_result("add_wrap", 4'h2);

    // Chaining: 0xA ^ 0x3 = 0x9, then 0x9 | 0x4 = 0xD.
    issue(2'd3, 4'hA, 4'h3, 1'b0);
    take_result("xor", 4'h9);
    issue(2'd1, 4'hF, 4'h4, 1'b1);
    check("chain_alu_a", 32'(alu_a), 32'h9);
    take_result("chain_or", 4'hD);

    // Backpressure: 1 + 2 = 3 held while a new command waits.
    issue(2'd0, 4'h1, 4'h2, 1'b0);
    tick();
    cmd_opcode = 2'd2;
    cmd_a      = 4'h8;
    cmd_b      = 4'h1;
    cmd_chain  = 1'b0;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  32'(res_valid),  32'd1);
      check("bp_data",   32'(res_data),   32'h3);
      check("bp_alu_a",  32'(alu_a),      32'h1);
      check("bp_alu_b",  32'(alu_b),      32'h2);
      check("bp_alu_op", 32'(alu_opcode), 32'd0);
      check("bp_ready",  32'(cmd_ready),  32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("bp_accept_a",  32'(alu_a),      32'h8);
    check("bp_accept_b",  32'(alu_b),      32'h1);
    check("bp_accept_op", 32'(alu_opcode), 32'd2);
    check("bp_accept_rdy", 32'(cmd_ready), 32'd0);
    take_result("bp_sub", 4'h7);

    // Reset mid-EXEC, asserted mid-cycle; acc was 0x7 and must clear.
    issue(2'd0, 4'h4, 4'h4, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready",  32'(cmd_ready),  32'd1);
    check("mid_rst_valid",  32'(res_valid),  32'd0);
    check("mid_rst_data",   32'(res_data),   32'd0);
    check("mid_rst_alu_a",  32'(alu_a),      32'd0);
    check("mid_rst_alu_b",  32'(alu_b),      32'd0);
    check("mid_rst_alu_op", 32'(alu_opcode), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(res_valid), 32'd0);
    issue(2'd0, 4'hC, 4'h6, 1'b1);
    check("post_rst_chain_a", 32'(alu_a), 32'd0);
    take_result("post_rst_chain", 4'h6);

    // Random commands against the reference model; stop at first miscompare.
    acc_m = 4'h6;
    for (int n = 0; n < 1000 && miscompares == 0; n++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_a     = 4'($urandom_range(0, 15));
      r_b     = 4'($urandom_range(0, 15));
      r_chain = 1'($urandom_range(0, 1));
      exp_a   = r_chain ? acc_m : r_a;
      exp_r   = alu_ref(r_op, exp_a, r_b);
      res_ready = 1'($urandom_range(0, 1));
      issue(r_op, r_a, r_b, r_chain);
      check("rnd_alu_a", 32'(alu_a), 32'(exp_a));
      res_ready = 1'($urandom_range(0, 1));
      tick();
      res_ready = 1'b0;
      check("rnd_valid", 32'(res_valid), 32'd1);
      check("rnd_data",  32'(res_data),  32'(exp_r));
      stall = int'($urandom_range(0, 3));
      repeat (stall) tick();
      check("rnd_held", 32'(res_data), 32'(exp_r));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      acc_m = exp_r;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
